// File: rtl/if_stage_q_if.sv
// Bundle between the fetch stage and its neighbours: redirect from EX/MEM,
// stall from decode, the instruction-memory port and the IF/ID register outputs.
interface if_stage_q_if #(
  parameter int XLEN     = 32,
  parameter int IW       = 32,
  parameter int FQ_DEPTH = 4
);
  localparam int LW = $clog2(FQ_DEPTH) + 1;

  logic            EX_MEM_PCSrc;
  logic [XLEN-1:0] EX_MEM_NPC;
  logic            id_stall;
  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic [IW-1:0]   imem_rdata;
  logic [IW-1:0]   IF_ID_instr;
  logic [XLEN-1:0] IF_ID_npc;
  logic            IF_ID_valid;
  logic [LW-1:0]   fq_level;

  // master: the fetch stage itself
  modport master (
    input  EX_MEM_PCSrc, EX_MEM_NPC, id_stall, imem_rdata,
    output imem_addr, imem_req, IF_ID_instr, IF_ID_npc, IF_ID_valid, fq_level
  );

  // slave: the surrounding pipeline and instruction memory
  modport slave (
    output EX_MEM_PCSrc, EX_MEM_NPC, id_stall, imem_rdata,
    input  imem_addr, imem_req, IF_ID_instr, IF_ID_npc, IF_ID_valid, fq_level
  );
endinterface

// File: rtl/if_stage_q.sv
// Instruction fetch stage with a small fetch queue decoupling imem fetches
// from the IF/ID register; redirects flush everything and restart the PC.
module if_stage_q #(
  parameter int              XLEN        = 32,
  parameter int              IW          = 32,
  parameter int              FQ_DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              INSTR_BYTES = 4,
  parameter logic [IW-1:0]   NOP_INSTR   = IW'(32'h0000_0013)
) (
  input logic         clk,
  input logic         rst,
  if_stage_q_if.master bus
);
  localparam int              PW         = $clog2(FQ_DEPTH);
  localparam int              LW         = PW + 1;
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));
  localparam logic [LW-1:0]   FULL_LVL   = LW'(FQ_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [XLEN-1:0] npc_q, npc_d;

  logic [IW-1:0]   fq_instr [FQ_DEPTH];
  logic [XLEN-1:0] fq_npc   [FQ_DEPTH];

  logic            push;
  logic            pop;
  logic            ifid_load;
  logic            fq_empty;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc    = pc_q + STEP;
  assign fq_empty  = (level_q == '0);
  // Full test uses the pre-edge level, so a same-cycle pop never frees a slot early.
  assign push      = !rst && !bus.EX_MEM_PCSrc && (level_q != FULL_LVL);
  assign ifid_load = !bus.id_stall || !valid_q;
  assign pop       = !rst && !bus.EX_MEM_PCSrc && ifid_load && !fq_empty;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    if (rst) begin
      pc_d     = RESET_PC;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      instr_d  = NOP_INSTR;
      npc_d    = '0;
    end else if (bus.EX_MEM_PCSrc) begin
      pc_d     = bus.EX_MEM_NPC & ALIGN_MASK;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      instr_d  = NOP_INSTR;
    end else begin
      if (push) begin
        pc_d     = pc_inc;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (ifid_load) begin
        if (fq_empty) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else begin
          valid_d  = 1'b1;
          instr_d  = fq_instr[rd_ptr_q];
          npc_d    = fq_npc[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
    valid_q  <= valid_d;
    instr_q  <= instr_d;
    npc_q    <= npc_d;
  end

  // Queue storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_instr[wr_ptr_q] <= bus.imem_rdata;
      fq_npc[wr_ptr_q]   <= pc_inc;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.imem_req    = push;
  assign bus.IF_ID_instr = instr_q;
  assign bus.IF_ID_npc   = npc_q;
  assign bus.IF_ID_valid = valid_q;
  assign bus.fq_level    = level_q;

endmodule

// File: tb/tb_if_stage_q.sv
// Randomised bench for if_stage_q: two instances (RESET_PC 0 and FFFFFFF8)
// share stimulus; a queue-based reference model feeds per-instance scoreboards.
module tb_if_stage_q;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_r   = 1'b1;
  logic        redir_r = 1'b0;
  logic [31:0] npc_r   = '0;
  logic        stall_r = 1'b0;

  if_stage_q_if bus0 ();
  if_stage_q_if bus1 ();

  function automatic logic [31:0] imem_word(logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus0.EX_MEM_PCSrc = redir_r;
  assign bus0.EX_MEM_NPC   = npc_r;
  assign bus0.id_stall     = stall_r;
  assign bus0.imem_rdata   = imem_word(bus0.imem_addr);
  assign bus1.EX_MEM_PCSrc = redir_r;
  assign bus1.EX_MEM_NPC   = npc_r;
  assign bus1.id_stall     = stall_r;
  assign bus1.imem_rdata   = imem_word(bus1.imem_addr);

  if_stage_q dut0 (.clk(clk), .rst(rst_r), .bus(bus0.master));
  if_stage_q #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst(rst_r), .bus(bus1.master));

  logic [31:0] o_addr [2];
  logic [31:0] o_instr[2];
  logic [31:0] o_npc  [2];
  logic        o_req  [2];
  logic        o_valid[2];
  logic [2:0]  o_lvl  [2];
  assign o_addr[0]  = bus0.imem_addr;   assign o_addr[1]  = bus1.imem_addr;
  assign o_instr[0] = bus0.IF_ID_instr; assign o_instr[1] = bus1.IF_ID_instr;
  assign o_npc[0]   = bus0.IF_ID_npc;   assign o_npc[1]   = bus1.IF_ID_npc;
  assign o_req[0]   = bus0.imem_req;    assign o_req[1]   = bus1.imem_req;
  assign o_valid[0] = bus0.IF_ID_valid; assign o_valid[1] = bus1.IF_ID_valid;
  assign o_lvl[0]   = bus0.fq_level;    assign o_lvl[1]   = bus1.fq_level;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: fetch queue of {instr, npc} entries plus IF/ID state.
  logic [31:0] rpc  [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] m_pc [2];
  logic        m_valid[2];
  logic [63:0] m_fq [2][$];
  logic [63:0] sb   [2][$];
  bit          mon_en = 1'b0;

  task automatic model_edge(int d);
    bit          full;
    logic [63:0] e;
    if (rst_r) begin
      m_pc[d] = rpc[d];
      m_fq[d].delete();
      m_valid[d] = 1'b0;
    end else if (redir_r) begin
      m_pc[d] = npc_r & ~32'h3;
      m_fq[d].delete();
      m_valid[d] = 1'b0;
    end else begin
      full = (m_fq[d].size() == 4);
      if (!stall_r || !m_valid[d]) begin
        if (m_fq[d].size() > 0) begin
          e = m_fq[d].pop_front();
          m_valid[d] = 1'b1;
          sb[d].push_back(e);
        end else begin
          m_valid[d] = 1'b0;
        end
      end
      if (!full) begin
        m_fq[d].push_back({imem_word(m_pc[d]), m_pc[d] + 32'd4});
        m_pc[d] = m_pc[d] + 32'd4;
      end
    end
  endtask

  task automatic step(bit r, bit rd, logic [31:0] np, bit st);
    rst_r   = r;
    redir_r = rd;
    npc_r   = np;
    stall_r = st;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
  endtask

  // Monitor: per-cycle state checks, and a scoreboard pop whenever IF/ID shows a new instruction.
  initial begin
    bit          pv[2];
    bit          ps;
    logic [63:0] held[2];
    logic [63:0] e;
    pv[0] = 1'b0; pv[1] = 1'b0; ps = 1'b0;
    held[0] = '0; held[1] = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d valid", d), 64'(o_valid[d]), 64'(m_valid[d]));
        chk($sformatf("dut%0d fq_level", d), 64'(o_lvl[d]), 64'(m_fq[d].size()));
        chk($sformatf("dut%0d imem_addr", d), 64'(o_addr[d]), 64'(m_pc[d]));
        chk($sformatf("dut%0d imem_req", d), 64'(o_req[d]),
            64'(!rst_r && !redir_r && (m_fq[d].size() < 4)));
        if (!o_valid[d]) begin
          chk($sformatf("dut%0d nop_instr", d), 64'(o_instr[d]), 64'(NOP));
        end else if (!pv[d] || !ps) begin
          if (sb[d].size() == 0) begin
            chk($sformatf("dut%0d unexpected_instr", d), 64'(o_instr[d]), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb[d].pop_front();
            held[d] = e;
            chk($sformatf("dut%0d sb_instr", d), 64'(o_instr[d]), 64'(e[63:32]));
            chk($sformatf("dut%0d sb_npc", d), 64'(o_npc[d]), 64'(e[31:0]));
          end
        end else begin
          chk($sformatf("dut%0d held_instr", d), 64'(o_instr[d]), 64'(held[d][63:32]));
          chk($sformatf("dut%0d held_npc", d), 64'(o_npc[d]), 64'(held[d][31:0]));
        end
        pv[d] = o_valid[d];
      end
      ps = stall_r;
    end
  end

  initial begin
    int i;
    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    mon_en = 1'b1;
    chk("rst valid", 64'(o_valid[0]), 64'd0);
    chk("rst level", 64'(o_lvl[0]), 64'd0);
    chk("rst instr", 64'(o_instr[0]), 64'(NOP));
    chk("rst npc", 64'(o_npc[0]), 64'd0);
    chk("rst pc", 64'(o_addr[0]), 64'd0);
    chk("rst pc dut1", 64'(o_addr[1]), 64'hFFFF_FFF8);

    // Release: first valid two edges later, then one per cycle; dut1 wraps
    step(0, 0, 0, 0);
    chk("edge1 valid", 64'(o_valid[0]), 64'd0);
    step(0, 0, 0, 0);
    chk("edge2 valid", 64'(o_valid[0]), 64'd1);
    chk("edge2 instr", 64'(o_instr[0]), 64'h1000_0000);
    chk("edge2 npc", 64'(o_npc[0]), 64'd4);
    chk("wrap npc0", 64'(o_npc[1]), 64'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("edge3 instr", 64'(o_instr[0]), 64'h1000_0001);
    chk("edge3 npc", 64'(o_npc[0]), 64'd8);
    chk("wrap npc1", 64'(o_npc[1]), 64'h0000_0000);
    step(0, 0, 0, 0);
    chk("edge4 instr", 64'(o_instr[0]), 64'h1000_0002);
    chk("edge4 npc", 64'(o_npc[0]), 64'd12);
    chk("wrap npc2", 64'(o_npc[1]), 64'h0000_0004);

    // Stall six cycles: hold, queue fills to 4, fetch stops
    repeat (6) step(0, 0, 0, 1);
    chk("stall held instr", 64'(o_instr[0]), 64'h1000_0002);
    chk("stall level full", 64'(o_lvl[0]), 64'd4);
    chk("stall req off", 64'(o_req[0]), 64'd0);
    repeat (6) step(0, 0, 0, 0);

    // Redirect to 0x43 with three entries queued
    step(1, 0, 0, 1);
    i = 0;
    while (i < 10 && m_fq[0].size() != 3) begin
      step(0, 0, 0, 1);
      i++;
    end
    chk("reach level3", 64'(o_lvl[0]), 64'd3);
    step(0, 1, 32'h0000_0043, 0);
    chk("redir level", 64'(o_lvl[0]), 64'd0);
    chk("redir valid", 64'(o_valid[0]), 64'd0);
    chk("redir pc", 64'(o_addr[0]), 64'h40);
    chk("redir instr", 64'(o_instr[0]), 64'(NOP));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("redir first instr", 64'(o_instr[0]), 64'h1000_0010);
    chk("redir first npc", 64'(o_npc[0]), 64'h44);

    // Redirect and stall together: redirect wins
    step(0, 1, 32'h0000_0100, 1);
    chk("redir+stall valid", 64'(o_valid[0]), 64'd0);
    chk("redir+stall pc", 64'(o_addr[0]), 64'h100);
    repeat (3) step(0, 0, 0, 0);

    // One-cycle reset with a full, stalled queue
    repeat (8) step(0, 0, 0, 1);
    chk("pre-rst full", 64'(o_lvl[0]), 64'd4);
    step(1, 1, 32'h0000_0200, 1);
    chk("midrst valid", 64'(o_valid[0]), 64'd0);
    chk("midrst level", 64'(o_lvl[0]), 64'd0);
    chk("midrst instr", 64'(o_instr[0]), 64'(NOP));
    chk("midrst npc", 64'(o_npc[0]), 64'd0);
    chk("midrst pc", 64'(o_addr[0]), 64'd0);
    chk("midrst pc dut1", 64'(o_addr[1]), 64'hFFFF_FFF8);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("restart instr", 64'(o_instr[0]), 64'h1000_0000);
    chk("restart npc", 64'(o_npc[0]), 64'd4);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           $urandom, ($urandom_range(0, 9) < 4));
    end
    repeat (8) step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb0 drained", 64'(sb[0].size()), 64'd0);
    chk("sb1 drained", 64'(sb[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/if_stage_q.md
IF_STAGE_Q -- requirements
Module: if_stage_q

Interface
REQ-001 Parameter XLEN, default 32, SHALL set PC/NPC width in bits.
REQ-002 Parameter IW, default 32, SHALL set instruction width in bits.
REQ-003 Parameter FQ_DEPTH, default 4, SHALL set fetch-queue entries; legal values are powers of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-005 Parameter INSTR_BYTES, default 4, SHALL set the PC increment; legal values are powers of two.
REQ-006 Parameter NOP_INSTR, default 32'h00000013, SHALL set the instruction driven while the output is invalid.
REQ-007 The block SHALL have one clock, clk, and one synchronous, active-high reset, rst.
REQ-008 Ports, one per line:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- EX_MEM_PCSrc  in  1  redirect request
- EX_MEM_NPC  in  XLEN  redirect target
- id_stall  in  1  decode stage cannot accept a new instruction
- imem_addr  out  XLEN  instruction memory address; equals PC
- imem_req  out  1  fetch-enable this cycle
- imem_rdata  in  IW  combinational read data for imem_addr
- IF_ID_instr  out  IW  IF/ID instruction
- IF_ID_npc  out  XLEN  IF/ID next PC (fetch address + INSTR_BYTES)
- IF_ID_valid  out  1  IF/ID holds a real instruction
- fq_level  out  $clog2(FQ_DEPTH)+1  fetch-queue occupancy

Function
REQ-009 The PC register SHALL drive imem_addr combinationally.
REQ-010 imem_req SHALL be 1 iff rst=0, EX_MEM_PCSrc=0, and fq_level < FQ_DEPTH.
REQ-011 When imem_req=1, on the clock edge the block SHALL push {imem_rdata, PC+INSTR_BYTES} into the queue tail and load PC with PC+INSTR_BYTES.
REQ-012 PC+INSTR_BYTES SHALL wrap modulo 2^XLEN with no flag.
REQ-013 When imem_req=0 and no redirect is pending, PC SHALL hold.
REQ-014 The full check SHALL use the pre-edge fq_level; a pop in the same cycle SHALL NOT enable a push when the queue is full.
REQ-015 IF/ID SHALL load when id_stall=0 or IF_ID_valid=0:
- queue non-empty: IF/ID takes the head entry (IF_ID_valid=1) and the head is popped.
- queue empty: IF_ID_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_npc holds its value.
REQ-016 When id_stall=1 and IF_ID_valid=1, IF/ID SHALL hold all three outputs unchanged and the queue SHALL NOT pop.
REQ-017 A push and a pop in the same cycle SHALL leave fq_level unchanged and preserve FIFO order.
REQ-018 Redirect (EX_MEM_PCSrc=1) SHALL take priority over stall, push and pop. On the edge:
- PC loads EX_MEM_NPC with its low log2(INSTR_BYTES) bits forced to 0.
- fq_level goes to 0 and the queue pointers reset.
- IF_ID_valid goes to 0 and IF_ID_instr goes to NOP_INSTR.
REQ-019 Latency SHALL be as follows:
- An instruction fetched at edge N appears valid in IF/ID at edge N+1 at the earliest.
- After reset release or a redirect, the first valid IF/ID instruction appears 2 edges later.
REQ-020 With id_stall=0 held, the steady state SHALL deliver one valid instruction per cycle.
REQ-021 The block SHALL use no combinational path from imem_rdata to any output.

Reset
REQ-022 While rst=1, on each edge the block SHALL set:
- PC=RESET_PC
- fq_level=0, queue pointers=0
- IF_ID_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_npc=0
REQ-023 rst SHALL override EX_MEM_PCSrc and id_stall, including when asserted mid-stream with a full queue.

Verification
REQ-024 The bench SHALL model imem as word-addressed data mem[a/4]=32'h1000_0000+a/4 and cover these scenarios:
- Reset release, id_stall=0 -> IF_ID_valid=1 from edge 2; instr 10000000, 10000001, 10000002… with npc 4, 8, 12…
- id_stall=1 for 6 cycles from the first valid -> IF/ID holds; fq_level rises to 4 and stays; imem_req=0 once full; on release, order resumes with no loss or duplicate.
- Redirect to 32'h0000_0043 while the queue holds 3 entries -> next edge: fq_level=0, IF_ID_valid=0, PC=32'h40; then instr 10000010 with npc 32'h44.
- Redirect and id_stall asserted together -> redirect wins; IF_ID_valid=0 next cycle.
- RESET_PC=32'hFFFF_FFF8 -> npc sequence FFFFFFFC, 00000000, 00000004 (wrap).
- rst pulsed for one cycle with the queue full and stalled -> all outputs at reset values; fetch restarts from RESET_PC.
